gps_srq_snap: RTL

- Parametrised service-request and snapshot serialiser for the GPS correlator bank. It is the successor to the fixed-width SRQ/snapshot logic in the GPS top level.
- Latches per-channel epoch requests and the host request. It shifts out a masked SRQ word, or an atomic {ticks, unserviced, replicas} snapshot, one bit per rdBit.
- New relative to the existing logic: per-channel saturating missed-epoch counters, readable as a third serial frame, plus a pending flag for the CPU.

---
 rtl/gps_srq_snap_pkg.sv | 36 +++
 rtl/gps_srq_snap_piso.sv | 37 +++
 rtl/gps_srq_snap.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gps_srq_snap_pkg.sv
// gps_srq_snap_pkg
// Shared constants for the GPS service-request / snapshot serialiser:
// default channel and field widths, frame-length helpers and the encodings
// of the frame-select register.
// No ports (package).
package gps_srq_snap_pkg;

  localparam int DEF_CHANS     = 12;
  localparam int DEF_REPL_BITS = 16;
  localparam int DEF_TICK_BITS = 48;
  localparam int DEF_MISS_BITS = 4;

  // Which serial frame currently drives ser.
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SRQ  = 2'd1;
  localparam logic [1:0] SEL_SNAP = 2'd2;
  localparam logic [1:0] SEL_MISS = 2'd3;

  // Frame lengths in bits.
  function automatic int srq_len(input int chans);
    return chans + 1;
  endfunction

  function automatic int snap_len(input int chans, input int tick_bits, input int repl_bits);
    return tick_bits + chans + chans * repl_bits;
  endfunction

  function automatic int miss_len(input int chans, input int miss_bits);
    return chans * miss_bits;
  endfunction

  localparam int DEF_SRQ_LEN  = srq_len(DEF_CHANS);
  localparam int DEF_SNAP_LEN = snap_len(DEF_CHANS, DEF_TICK_BITS, DEF_REPL_BITS);
  localparam int DEF_MISS_LEN = miss_len(DEF_CHANS, DEF_MISS_BITS);

endpackage

// File: rtl/gps_srq_snap_piso.sv
// gps_piso
// Parallel-in / serial-out register. The parallel word is captured on load;
// each shift moves it one place towards the MSB, filling with zero, so once
// the word has been fully shifted out ser stays low.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the register
//   load  - capture din (takes precedence over shift)
//   shift - advance by one bit
//   din   - parallel word, MSB is presented first
//   ser   - current MSB
module gps_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             ser
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= din;
    end else if (shift) begin
      r_data <= r_data << 1;
    end
  end

  assign ser = r_data[WIDTH-1];

endmodule

// File: rtl/gps_srq_snap.sv
// gps_srq_snap
// Service-request and snapshot serialiser for the GPS correlator bank.
// Latches per-channel epoch pulses, counts epochs that arrive before the
// previous one was serviced, and serialises one of three frames:
//   SRQ  : {host_srq, (noted|srq_in) & mask}
//   SNAP : {ticks, srq_in|noted, replica}      (single-cycle, coherent)
//   MISS : {miss[CHANS-1], ..., miss[0]}       (counters cleared on capture)
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   srq_in                - per-channel epoch pulses
//   host_srq              - host service request (level)
//   mask_wr, mask_din     - channel mask write
//   ticks, replica        - snapshot sources (replica ch0 in LSBs)
//   load_srq/snap/miss    - frame capture strobes (priority srq>snap>miss)
//   shift                 - advance the selected frame by one bit
//   ser                   - MSB of the selected frame
//   srq_pending           - |(noted & mask) | host_srq
module gps_srq_snap
  import gps_srq_snap_pkg::*;
#(
  parameter int CHANS     = DEF_CHANS,
  parameter int REPL_BITS = DEF_REPL_BITS,
  parameter int TICK_BITS = DEF_TICK_BITS,
  parameter int MISS_BITS = DEF_MISS_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANS-1:0]           srq_in,
  input  logic                       host_srq,
  input  logic                       mask_wr,
  input  logic [CHANS-1:0]           mask_din,
  input  logic [TICK_BITS-1:0]       ticks,
  input  logic [CHANS*REPL_BITS-1:0] replica,
  input  logic                       load_srq,
  input  logic                       load_snap,
  input  logic                       load_miss,
  input  logic                       shift,
  output logic                       ser,
  output logic                       srq_pending
);

  localparam int SRQ_LEN  = srq_len(CHANS);
  localparam int SNAP_LEN = snap_len(CHANS, TICK_BITS, REPL_BITS);
  localparam int MISS_LEN = miss_len(CHANS, MISS_BITS);

  logic [CHANS-1:0] r_noted;
  logic [CHANS-1:0] r_mask;
  logic [1:0]       r_sel;

  // Load arbitration: only the highest-priority strobe captures its frame.
  logic w_srq_win;
  logic w_snap_win;
  logic w_miss_win;
  logic w_any_load;
  logic w_shift_ok;

  assign w_srq_win  = load_srq;
  assign w_snap_win = load_snap & ~load_srq;
  assign w_miss_win = load_miss & ~load_srq & ~load_snap;
  assign w_any_load = load_srq | load_snap | load_miss;
  // A load in the same cycle suppresses the shift.
  assign w_shift_ok = shift & ~w_any_load;

  // Frame sources.
  logic [SRQ_LEN-1:0]  w_srq_frame;
  logic [SNAP_LEN-1:0] w_snap_frame;
  logic [MISS_LEN-1:0] w_miss_frame;

  // A pulse coinciding with load_srq is already part of this frame, yet
  // is still kept in noted for the following frame.
  assign w_srq_frame  = {host_srq, (r_noted | srq_in) & r_mask};
  assign w_snap_frame = {ticks, srq_in | r_noted, replica};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_noted <= '0;
      r_mask  <= '0;
      r_sel   <= SEL_NONE;
    end else begin
      r_noted <= load_srq ? srq_in : (r_noted | srq_in);
      if (mask_wr) begin
        r_mask <= mask_din;
      end
      if (w_srq_win) begin
        r_sel <= SEL_SRQ;
      end else if (w_snap_win) begin
        r_sel <= SEL_SNAP;
      end else if (w_miss_win) begin
        r_sel <= SEL_MISS;
      end
    end
  end

  // Missed-epoch counters: a second pulse on a channel that is still noted
  // (and not being serviced this cycle) is a missed epoch. Masked channels
  // count too. Clearing on capture keeps a coincident increment as 1.
  genvar gi;
  generate
    for (gi = 0; gi < CHANS; gi++) begin : g_miss
      logic                 w_inc;
      logic [MISS_BITS-1:0] r_cnt;

      assign w_inc = srq_in[gi] & r_noted[gi] & ~load_srq;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_miss_win) begin
          r_cnt <= w_inc ? MISS_BITS'(1) : '0;
        end else if (w_inc && (r_cnt != {MISS_BITS{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_miss_frame[gi*MISS_BITS +: MISS_BITS] = r_cnt;
    end
  endgenerate

  logic w_ser_srq;
  logic w_ser_snap;
  logic w_ser_miss;

  gps_piso #(.WIDTH(SRQ_LEN)) u_piso_srq (
    .clk   (clk),
    .rst   (rst),
    .load  (w_srq_win),
    .shift (w_shift_ok & (r_sel == SEL_SRQ)),
    .din   (w_srq_frame),
    .ser   (w_ser_srq)
  );

  gps_piso #(.WIDTH(SNAP_LEN)) u_piso_snap (
    .clk   (clk),
    .rst   (rst),
    .load  (w_snap_win),
    .shift (w_shift_ok & (r_sel == SEL_SNAP)),
    .din   (w_snap_frame),
    .ser   (w_ser_snap)
  );

  gps_piso #(.WIDTH(MISS_LEN)) u_piso_miss (
    .clk   (clk),
    .rst   (rst),
    .load  (w_miss_win),
    .shift (w_shift_ok & (r_sel == SEL_MISS)),
    .din   (w_miss_frame),
    .ser   (w_ser_miss)
  );

  always_comb begin
    ser = 1'b0;
    case (r_sel)
      SEL_SRQ:  ser = w_ser_srq;
      SEL_SNAP: ser = w_ser_snap;
      SEL_MISS: ser = w_ser_miss;
      default:  ser = 1'b0;
    endcase
  end

  assign srq_pending = (|(r_noted & r_mask)) | host_srq;

endmodule
